// File: rtl/mul_unit_iter.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), STEP bits per cycle.
// Ports: clk_i, rst_n_i, start_i, alu_op_i, op_a_i, op_b_i, flush_i,
//        stall_o, busy_o, valid_o, result_o.
module mul_unit_iter #(
  parameter int         XLEN       = 32,
  parameter int         STEP       = 1,
  parameter logic [3:0] ALU_MUL    = 4'd10,
  parameter logic [3:0] ALU_MULH   = 4'd11,
  parameter logic [3:0] ALU_MULHSU = 4'd12,
  parameter logic [3:0] ALU_MULHU  = 4'd13
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N  = XLEN / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_lo;
  logic [XLEN-1:0] r_result;

  logic            w_is_mul;
  logic            w_accept;
  logic            w_a_sgn;
  logic            w_b_sgn;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_prod;
  logic [XLEN-1:0] w_new;
  logic            w_last;
  logic            w_done_ok;

  assign w_is_mul = (alu_op_i == ALU_MUL)
                  | (alu_op_i == ALU_MULH)
                  | (alu_op_i == ALU_MULHSU)
                  | (alu_op_i == ALU_MULHU);

  assign w_accept = (r_state == S_IDLE) & start_i
                  & w_is_mul & ~flush_i;

  assign w_a_sgn = (alu_op_i == ALU_MULH)
                 | (alu_op_i == ALU_MULHSU);
  assign w_b_sgn = (alu_op_i == ALU_MULH);

  assign w_a_neg = w_a_sgn & op_a_i[XLEN-1];
  assign w_b_neg = w_b_sgn & op_b_i[XLEN-1];

  // |0x80..0| wraps to itself, which is the right unsigned magnitude
  assign w_a_abs = w_a_neg ? (~op_a_i + XLEN'(1)) : op_a_i;
  assign w_b_abs = w_b_neg ? (~op_b_i + XLEN'(1)) : op_b_i;

  // multiplicand is pre-shifted each cycle, so the shift count is implicit
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < STEP; j++) begin
      if (r_mplier[j]) begin
        w_pp = w_pp + (r_mcand << j);
      end
    end
  end

  assign w_prod = r_neg ? (~r_acc + PW'(1)) : r_acc;
  assign w_new  = r_lo ? w_prod[XLEN-1:0]
                       : w_prod[PW-1:XLEN];

  assign w_last    = (r_cnt == CW'(N - 1));
  assign w_done_ok = (r_state == S_DONE) & ~flush_i;

  assign stall_o  = w_accept | (r_state == S_BUSY);
  assign busy_o   = (r_state == S_BUSY);
  assign valid_o  = w_done_ok;
  assign result_o = w_done_ok ? w_new : r_result;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else if (flush_i) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_BUSY;
        S_BUSY: if (w_last) r_state <= S_DONE;
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_lo     <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_acc    <= '0;
        r_mcand  <= {{XLEN{1'b0}}, w_a_abs};
        r_mplier <= w_b_abs;
        r_cnt    <= '0;
        r_neg    <= w_a_neg ^ w_b_neg;
        r_lo     <= (alu_op_i == ALU_MUL);
      end else if (r_state == S_BUSY) begin
        r_acc    <= r_acc + w_pp;
        r_mcand  <= r_mcand << STEP;
        r_mplier <= r_mplier >> STEP;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_done_ok) begin
        r_result <= w_new;
      end
    end
  end

endmodule
